// File: rtl/uart_result_tx_if.sv
// Byte handshake and serial/status signals between the result core and the TXD transmitter.
interface uart_result_tx_if;
    logic [7:0] DATA_IN;
    logic       DATA_VALID;
    logic       DATA_READY;
    logic       TXD;
    logic       TX_BUSY;
    logic [4:0] FIFO_LEVEL;

    modport master (
        output DATA_IN, DATA_VALID,
        input  DATA_READY, TXD, TX_BUSY, FIFO_LEVEL
    );

    modport slave (
        input  DATA_IN, DATA_VALID,
        output DATA_READY, TXD, TX_BUSY, FIFO_LEVEL
    );
endinterface

// File: rtl/uart_result_tx.sv
// UART transmitter returning result/status bytes to the host through a small byte FIFO, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); otherwise frames are 8N1.
module uart_result_tx #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input logic            CLK,
    input logic            RESET,
    uart_result_tx_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned LVL_W = 5;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             txd;
`ifdef UART_TX_PARITY_EN
    logic             parity;
`endif

    logic ready;
    logic push;
    logic pop;
    logic bit_end;

    assign ready   = (level != LVL_W'(FIFO_DEPTH));
    assign push    = bus.DATA_VALID && ready;
    assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    // A byte leaves the FIFO when idle, or at the end of a stop bit for back-to-back frames.
    assign pop     = (level != '0) && ((state == IDLE) || ((state == STOP) && bit_end));

    assign bus.DATA_READY = ready;
    assign bus.TXD        = txd;
    assign bus.TX_BUSY    = (state != IDLE) || (level != '0);
    assign bus.FIFO_LEVEL = level;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      level <= level + LVL_W'(1);
            else if (!push && pop) level <= level - LVL_W'(1);
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= bus.DATA_IN;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            if (state == IDLE || bit_end) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity <= ^mem[rd_ptr];
`endif
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        txd     <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= parity;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            txd     <= shift[1];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                            parity <= ^mem[rd_ptr];
`endif
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            txd   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_result_tx.sv
// Randomised bench for uart_result_tx: a queue-and-frame-timer model predicts TXD, level, ready and busy every cycle.
module tb_uart_result_tx;
    localparam int unsigned C     = 4;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_result_tx_if bus();

    uart_result_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: pending bytes in a queue, current frame as elapsed-cycle count.
    logic [7:0] q[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_in_frame = 1'b0;
    int         m_t = 0;
    bit         chk_en = 1'b0;

    function automatic logic exp_txd();
        int k;
        if (!m_in_frame) return 1'b1;
        k = m_t / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^m_cur;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        if (rst) begin
            q.delete();
            m_in_frame = 1'b0;
            m_t = 0;
        end else begin
            do_push = bus.DATA_VALID && (q.size() < DEPTH);
            do_pop  = (q.size() != 0) && (!m_in_frame || m_t == FRAME - 1);
            if (m_in_frame) begin
                m_t++;
                if (m_t == FRAME) m_in_frame = 1'b0;
            end
            if (do_pop) begin
                m_cur = q.pop_front();
                m_in_frame = 1'b1;
                m_t = 0;
            end
            if (do_push) q.push_back(bus.DATA_IN);
        end
        #1;
        if (chk_en) begin
            check("txd",   32'(bus.TXD),        32'(exp_txd()));
            check("level", 32'(bus.FIFO_LEVEL), 32'(q.size()));
            check("ready", 32'(bus.DATA_READY), 32'(q.size() != DEPTH));
            check("busy",  32'(bus.TX_BUSY),    32'(m_in_frame || q.size() != 0));
        end
    end

    task automatic push1(input logic [7:0] b);
        @(negedge clk);
        bus.DATA_VALID = 1'b1;
        bus.DATA_IN    = b;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 12 * FRAME && (bus.TX_BUSY !== 1'b0); i++) @(negedge clk);
        check(tag, 32'(bus.TX_BUSY), 32'd0);
    endtask

    initial begin
        int n;
        bus.DATA_VALID = 1'b0;
        bus.DATA_IN    = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_txd",   32'(bus.TXD),        32'd1);
        check("rst_ready", 32'(bus.DATA_READY), 32'd1);
        check("rst_busy",  32'(bus.TX_BUSY),    32'd0);
        check("rst_level", 32'(bus.FIFO_LEVEL), 32'd0);

        // Single byte: busy ends one full frame after the pop edge.
        @(negedge clk);
        bus.DATA_VALID = 1'b1;
        bus.DATA_IN    = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.TX_BUSY) break;
        end
        check("busy_drop_edge", 32'(n), 32'(1 + FRAME));
        repeat (3) @(negedge clk);
        check("idle_txd", 32'(bus.TXD), 32'd1);

        // Queue three bytes while a frame is in flight.
        push1(8'h55);
        repeat (2) @(negedge clk);
        bus.DATA_VALID = 1'b1;
        bus.DATA_IN    = 8'h00;
        @(negedge clk);
        check("lvl1", 32'(bus.FIFO_LEVEL), 32'd1);
        bus.DATA_IN = 8'hFF;
        @(negedge clk);
        check("lvl2", 32'(bus.FIFO_LEVEL), 32'd2);
        bus.DATA_IN = 8'h3C;
        @(negedge clk);
        check("lvl3", 32'(bus.FIFO_LEVEL), 32'd3);
        bus.DATA_VALID = 1'b0;

        // Push on the same edge as a back-to-back pop with two bytes queued.
        for (int i = 0; i < 4 * FRAME && !(m_in_frame && m_t == FRAME - 1 && q.size() == 2); i++)
            @(negedge clk);
        check("pushpop_sync", 32'(m_t), 32'(FRAME - 1));
        push1(8'h81);
        check("pushpop_level", 32'(bus.FIFO_LEVEL), 32'd2);
        drain("drain_b2b");

        // Parity-sensitive bytes.
        push1(8'h07);
        push1(8'h03);
        drain("drain_parity");

        // Hold valid high with fresh data every cycle to run the FIFO full.
        for (int i = 0; i < 6 * FRAME; i++) begin
            @(negedge clk);
            bus.DATA_VALID = 1'b1;
            bus.DATA_IN    = 8'($urandom);
        end
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        drain("drain_full");

        // Reset during data bit 3 with two bytes queued.
        @(negedge clk);
        bus.DATA_VALID = 1'b1;
        bus.DATA_IN = 8'hC3;
        @(negedge clk);
        bus.DATA_IN = 8'h5A;
        @(negedge clk);
        bus.DATA_IN = 8'h96;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < 2 * FRAME && !(m_in_frame && m_t == 4 * C + 1); i++) @(negedge clk);
        check("rst_sync", 32'(m_t), 32'(4 * C + 1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_txd",   32'(bus.TXD),        32'd1);
        check("midrst_level", 32'(bus.FIFO_LEVEL), 32'd0);
        check("midrst_busy",  32'(bus.TX_BUSY),    32'd0);
        repeat (2 * FRAME) @(negedge clk);
        check("post_rst_txd",  32'(bus.TXD),     32'd1);
        check("post_rst_busy", 32'(bus.TX_BUSY), 32'd0);

        // Random traffic with varying density.
        for (int p = 0; p < 8; p++) begin
            int dens;
            dens = $urandom_range(1, 8);
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                bus.DATA_VALID = ($urandom_range(0, 7) < dens);
                bus.DATA_IN    = 8'($urandom);
            end
        end
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        drain("drain_random");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
